// File: rtl/rl_ram_1r1w_bist.sv
// March C- BIST initiator for a 1R1W RAM: drives both ports, checks read data and keeps first-failure diagnostics.
// Optional RL_RAM_BIST_ERRCNT_EN: adds err_cnt_o and runs the full march instead of stopping at the first mismatch.
module rl_ram_1r1w_bist #(
    parameter int ABITS = 10,
    parameter int DBITS = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   fail_o,
    output logic [ABITS-1:0]       fail_addr_o,
    output logic [2:0]             fail_elem_o,
    output logic [DBITS-1:0]       fail_data_o,
    output logic [ABITS-1:0]       ram_waddr_o,
    output logic [DBITS-1:0]       ram_din_o,
    output logic                   ram_we_o,
    output logic [(DBITS+7)/8-1:0] ram_be_o,
    output logic [ABITS-1:0]       ram_raddr_o,
    output logic                   ram_re_o,
    input  logic [DBITS-1:0]       ram_dout_i,
`ifdef RL_RAM_BIST_ERRCNT_EN
    output logic [15:0]            err_cnt_o,
`endif
    output logic [2:0]             dbg_state_o
);

    localparam int BBITS = (DBITS + 7) / 8;
    localparam logic [ABITS-1:0] LAST = {ABITS{1'b1}};

`ifdef RL_RAM_BIST_ERRCNT_EN
    localparam logic STOP_ON_FAIL = 1'b0;
`else
    localparam logic STOP_ON_FAIL = 1'b1;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_W0      = 3'd1,
        S_RD      = 3'd2,
        S_CMP     = 3'd3,
        S_R5      = 3'd4,
        S_R5_TAIL = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [ABITS-1:0] addr_q, addr_d;
    logic [2:0]       elem_q, elem_d;
    logic             fail_q;
    logic [ABITS-1:0] fail_addr_q;
    logic [2:0]       fail_elem_q;
    logic [DBITS-1:0] fail_data_q;

    logic             up;
    logic             at_end;
    logic [ABITS-1:0] addr_step;
    logic [DBITS-1:0] bg;
    logic             cmp_valid;
    logic [DBITS-1:0] cmp_exp;
    logic [ABITS-1:0] cmp_addr;
    logic             mismatch;
    logic             start_ok;

    // Element ordering / background: E3,E4 run downward; E2,E4 expect all-ones.
    always_comb begin
        up        = (elem_q != 3'd3) && (elem_q != 3'd4);
        bg        = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? {DBITS{1'b1}} : {DBITS{1'b0}};
        at_end    = up ? (addr_q == LAST) : (addr_q == '0);
        addr_step = up ? addr_q + 1'b1 : addr_q - 1'b1;
    end

    // In R5 the data returning now belongs to the previous address.
    always_comb begin
        cmp_valid = (state_q == S_CMP) || (state_q == S_R5_TAIL) ||
                    ((state_q == S_R5) && (addr_q != '0));
        cmp_exp   = (state_q == S_CMP) ? bg : {DBITS{1'b0}};
        cmp_addr  = (state_q == S_R5) ? addr_q - 1'b1 : addr_q;
        mismatch  = cmp_valid && (ram_dout_i != cmp_exp);
        start_ok  = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        elem_d      = elem_q;
        ram_we_o    = 1'b0;
        ram_re_o    = 1'b0;
        ram_din_o   = {DBITS{1'b0}};
        ram_waddr_o = addr_q;
        ram_raddr_o = addr_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_W0;
                    addr_d  = '0;
                    elem_d  = 3'd0;
                end
            end
            S_W0: begin
                ram_we_o = 1'b1;
                addr_d   = addr_q + 1'b1;
                if (addr_q == LAST) begin
                    state_d = S_RD;
                    elem_d  = 3'd1;
                    addr_d  = '0;
                end
            end
            S_RD: begin
                ram_re_o = 1'b1;
                state_d  = S_CMP;
            end
            S_CMP: begin
                if (mismatch && STOP_ON_FAIL) begin
                    state_d = S_DONE;
                end else begin
                    ram_we_o  = 1'b1;
                    ram_din_o = ~bg;
                    state_d   = S_RD;
                    addr_d    = addr_step;
                    if (at_end) begin
                        elem_d = elem_q + 3'd1;
                        case (elem_q)
                            3'd1:    addr_d = '0;
                            3'd2:    addr_d = LAST;
                            3'd3:    addr_d = LAST;
                            default: begin
                                addr_d  = '0;
                                state_d = S_R5;
                            end
                        endcase
                    end
                end
            end
            S_R5: begin
                if (mismatch && STOP_ON_FAIL) begin
                    state_d = S_DONE;
                end else begin
                    ram_re_o = 1'b1;
                    if (addr_q == LAST) state_d = S_R5_TAIL;
                    else                addr_d  = addr_q + 1'b1;
                end
            end
            S_R5_TAIL: state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            elem_q      <= 3'd0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= 3'd0;
            fail_data_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            elem_q  <= elem_d;
            if (start_ok) begin
                fail_q      <= 1'b0;
                fail_addr_q <= '0;
                fail_elem_q <= 3'd0;
                fail_data_q <= '0;
            end else if (mismatch && !fail_q) begin
                fail_q      <= 1'b1;
                fail_addr_q <= cmp_addr;
                fail_elem_q <= elem_q;
                fail_data_q <= ram_dout_i;
            end
        end
    end

`ifdef RL_RAM_BIST_ERRCNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || start_ok)                   err_cnt_q <= 16'd0;
        else if (mismatch && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end

    assign err_cnt_o = err_cnt_q;
`endif

    assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o      = (state_q == S_DONE);
    assign fail_o      = fail_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_elem_o = fail_elem_q;
    assign fail_data_o = fail_data_q;
    assign ram_be_o    = ram_we_o ? {BBITS{1'b1}} : {BBITS{1'b0}};
    assign dbg_state_o = state_q;

endmodule
